// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle MIPS control unit.
//
// Steps each instruction through fetch (IF), decode (ID) and one or more
// execute/writeback states, then returns to IF. Drives the ALU operation
// code, the datapath mux selects and the write strobes for the PC, IR,
// register file and memory interface.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   OPcode, Fun         instruction fields IR[31:26] and IR[5:0]
//   zero, overflow      ALU flags, valid in the same cycle
//   MIO_ready           memory handshake: a memory access completes in a
//                       cycle where MIO_ready is 1. IF, MR and MW keep their
//                       request asserted and hold state until it is seen.
//   ALU_operation       0 AND,1 OR,2 ADD,3 XOR,4 NOR,5 SRL,6 SUB,7 SLT,8 SLL
//   ALUSrcA, ALUSrcB    ALU operand selects
//   imm_zext            1: zero-extend immediate, 0: sign-extend
//   RegDst, MemtoReg    register-file write address / data selects
//   PCSource, pc_we     PC next-value select and write enable
//   IorD                memory address select (0 PC, 1 ALUOut)
//   IRWrite, MemRead, MemWrite, RegWrite   strobes
//   illegal             one-cycle pulse in ID on an unsupported instruction
//   state               current FSM state (debug)
module mcpu_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      OPcode,
    input  logic [5:0]      Fun,
    input  logic            zero,
    input  logic            overflow,
    input  logic            MIO_ready,
    output logic [3:0]      ALU_operation,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            imm_zext,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      PCSource,
    output logic            pc_we,
    output logic            IorD,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3,
        S_LWB = 4'd4,  S_MW  = 4'd5,  S_REX = 4'd6,  S_RWB = 4'd7,
        S_BR  = 4'd8,  S_J   = 4'd9,  S_IEX = 4'd10, S_IWB = 4'd11,
        S_JAL = 4'd12, S_JR  = 4'd13
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2,
                           ALU_XOR = 4'd3, ALU_NOR = 4'd4, ALU_SRL = 4'd5,
                           ALU_SUB = 4'd6, ALU_SLT = 4'd7, ALU_SLL = 4'd8;

    state_t state_q, state_d;
    logic   ovf_q, ovf_d;   // overflow seen during an add/sub/addi execute

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign state = ST_W'(state_q);

    always_comb begin
        state_d       = state_q;
        ovf_d         = ovf_q;
        ALU_operation = ALU_ADD;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        imm_zext      = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        PCSource      = 2'b00;
        pc_we         = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        illegal       = 1'b0;

        // Under reset every output stays at its default so an aborted
        // instruction cannot write anything in the reset cycle.
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (MIO_ready) begin
                        IRWrite = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    // Branch target is computed here speculatively into ALUOut.
                    ALUSrcB = 2'b11;
                    ovf_d   = 1'b0;
                    state_d = S_IF;
                    case (OPcode)
                        6'h00: begin
                            case (Fun)
                                6'h08: state_d = S_JR;
                                6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h00, 6'h02: state_d = S_REX;
                                default: illegal = 1'b1;
                            endcase
                        end
                        6'h23, 6'h2B: state_d = S_MA;
                        6'h04, 6'h05: state_d = S_BR;
                        6'h02:        state_d = S_J;
                        6'h03:        state_d = S_JAL;
                        6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: state_d = S_IEX;
                        default:      illegal = 1'b1;
                    endcase
                end
                S_REX: begin
                    ALUSrcA = (Fun == 6'h00 || Fun == 6'h02) ? 2'b10 : 2'b01;
                    case (Fun)
                        6'h22:   ALU_operation = ALU_SUB;
                        6'h24:   ALU_operation = ALU_AND;
                        6'h25:   ALU_operation = ALU_OR;
                        6'h26:   ALU_operation = ALU_XOR;
                        6'h27:   ALU_operation = ALU_NOR;
                        6'h2A:   ALU_operation = ALU_SLT;
                        6'h00:   ALU_operation = ALU_SLL;
                        6'h02:   ALU_operation = ALU_SRL;
                        default: ALU_operation = ALU_ADD;
                    endcase
                    // Only the trapping arithmetic ops suppress writeback.
                    ovf_d   = overflow & (Fun == 6'h20 || Fun == 6'h22);
                    state_d = S_RWB;
                end
                S_RWB: begin
                    RegDst   = 2'b01;
                    RegWrite = ~ovf_q;
                    state_d  = S_IF;
                end
                S_IEX: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    imm_zext = (OPcode == 6'h0C || OPcode == 6'h0D || OPcode == 6'h0E);
                    case (OPcode)
                        6'h0A:   ALU_operation = ALU_SLT;
                        6'h0C:   ALU_operation = ALU_AND;
                        6'h0D:   ALU_operation = ALU_OR;
                        6'h0E:   ALU_operation = ALU_XOR;
                        default: ALU_operation = ALU_ADD;
                    endcase
                    ovf_d   = overflow & (OPcode == 6'h08);
                    state_d = S_IWB;
                end
                S_IWB: begin
                    RegWrite = ~ovf_q;
                    state_d  = S_IF;
                end
                S_MA: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    state_d = (OPcode == 6'h23) ? S_MR : S_MW;
                end
                S_MR: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    if (MIO_ready) state_d = S_LWB;
                end
                S_LWB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                    state_d  = S_IF;
                end
                S_MW: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    if (MIO_ready) state_d = S_IF;
                end
                S_BR: begin
                    ALUSrcA       = 2'b01;
                    ALU_operation = ALU_SUB;
                    PCSource      = 2'b01;
                    // beq takes on zero, bne on not-zero.
                    pc_we         = zero ^ (OPcode == 6'h05);
                    state_d       = S_IF;
                end
                S_J: begin
                    PCSource = 2'b10;
                    pc_we    = 1'b1;
                    state_d  = S_IF;
                end
                S_JAL: begin
                    // PC already holds the return address (PC+4) from IF.
                    PCSource = 2'b10;
                    pc_we    = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                    state_d  = S_IF;
                end
                S_JR: begin
                    PCSource = 2'b11;
                    pc_we    = 1'b1;
                    state_d  = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_ctrl.sv
module tb_mcpu_ctrl;

    logic       clk, rst;
    logic [5:0] OPcode, Fun;
    logic       zero, overflow, MIO_ready;
    logic [3:0] ALU_operation;
    logic [1:0] ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource;
    logic       imm_zext, pc_we, IorD, IRWrite, MemRead, MemWrite, RegWrite, illegal;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    mcpu_ctrl #(.ST_W(4)) dut (
        .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero),
        .overflow(overflow), .MIO_ready(MIO_ready), .ALU_operation(ALU_operation),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .imm_zext(imm_zext), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .PCSource(PCSource), .pc_we(pc_we), .IorD(IorD),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .illegal(illegal), .state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are then sampled mid-cycle
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // IF with ready=1 for the given instruction, then step into ID
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        OPcode = op;
        Fun    = fn;
        check("if_state", state, 0);
        check("if_irwrite", IRWrite, 1);
        cyc();
        check("id_state", state, 1);
    endtask

    initial begin
        rst = 1'b1; OPcode = 6'h00; Fun = 6'h00;
        zero = 1'b0; overflow = 1'b0; MIO_ready = 1'b1;
        cyc(); cyc();

        // reset outputs
        check("rst_state", state, 0);
        check("rst_memread", MemRead, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_alusrcb", ALUSrcB, 0);
        check("rst_aluop", ALU_operation, 2);
        rst = 1'b0;
        #1;

        // IF decode
        check("if_memread", MemRead, 1);
        check("if_alusrcb", ALUSrcB, 1);
        check("if_pc_we", pc_we, 1);

        // add, no overflow
        fetch(6'h00, 6'h20);
        check("id_alusrcb", ALUSrcB, 3);
        check("id_illegal", illegal, 0);
        cyc();
        check("rex_state", state, 6);
        check("rex_aluop", ALU_operation, 2);
        check("rex_alusrca", ALUSrcA, 1);
        check("rex_alusrcb", ALUSrcB, 0);
        cyc();
        check("rwb_state", state, 7);
        check("rwb_regwrite", RegWrite, 1);
        check("rwb_regdst", RegDst, 1);
        cyc();
        check("add_back_if", state, 0);

        // add with overflow
        fetch(6'h00, 6'h20);
        cyc();
        overflow = 1'b1;
        #1;
        cyc();
        overflow = 1'b0;
        check("add_ovf_regwrite", RegWrite, 0);
        cyc();

        // sub (no overflow) right after: flag cleared in ID
        fetch(6'h00, 6'h22);
        cyc();
        check("sub_aluop", ALU_operation, 6);
        cyc();
        check("sub_regwrite", RegWrite, 1);
        cyc();

        // sll: shamt source
        fetch(6'h00, 6'h00);
        cyc();
        check("sll_aluop", ALU_operation, 8);
        check("sll_alusrca", ALUSrcA, 2);
        cyc(); cyc();

        // addi with overflow
        fetch(6'h08, 6'h00);
        cyc();
        check("iex_state", state, 10);
        check("iex_alusrcb", ALUSrcB, 2);
        check("addi_zext", imm_zext, 0);
        overflow = 1'b1;
        #1;
        cyc();
        check("iwb_state", state, 11);
        check("addi_ovf_regwrite", RegWrite, 0);
        cyc();

        // ori with overflow asserted: not latched, zero-extended
        fetch(6'h0D, 6'h00);
        cyc();
        check("ori_aluop", ALU_operation, 1);
        check("ori_zext", imm_zext, 1);
        cyc();
        check("ori_regwrite", RegWrite, 1);
        check("ori_regdst", RegDst, 0);
        overflow = 1'b0;
        cyc();

        // lw with 3 stall cycles in MR
        fetch(6'h23, 6'h00);
        cyc();
        check("ma_state", state, 2);
        check("ma_alusrcb", ALUSrcB, 2);
        MIO_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("mr_state", state, 3);
            check("mr_memread", MemRead, 1);
            check("mr_iord", IorD, 1);
            cyc();
        end
        check("mr_hold_state", state, 3);
        MIO_ready = 1'b1;
        cyc();
        check("lwb_state", state, 4);
        check("lwb_memtoreg", MemtoReg, 1);
        check("lwb_regwrite", RegWrite, 1);
        cyc();

        // beq zero=1
        fetch(6'h04, 6'h00);
        zero = 1'b1;
        cyc();
        check("br_state", state, 8);
        check("beq_z1_pc_we", pc_we, 1);
        check("br_pcsource", PCSource, 1);
        check("br_aluop", ALU_operation, 6);
        cyc();
        // bne zero=1, then zero=0
        fetch(6'h05, 6'h00);
        cyc();
        check("bne_z1_pc_we", pc_we, 0);
        zero = 1'b0;
        #1;
        check("bne_z0_pc_we", pc_we, 1);
        cyc();
        check("br_back_if", state, 0);

        // jal
        fetch(6'h03, 6'h00);
        cyc();
        check("jal_state", state, 12);
        check("jal_regdst", RegDst, 2);
        check("jal_memtoreg", MemtoReg, 2);
        check("jal_regwrite", RegWrite, 1);
        check("jal_pcsource", PCSource, 2);
        cyc();

        // jr
        fetch(6'h00, 6'h08);
        cyc();
        check("jr_state", state, 13);
        check("jr_pcsource", PCSource, 3);
        check("jr_pc_we", pc_we, 1);
        cyc();

        // illegal opcode
        fetch(6'h3F, 6'h00);
        check("ill_pulse", illegal, 1);
        check("ill_regwrite", RegWrite, 0);
        check("ill_memwrite", MemWrite, 0);
        cyc();
        check("ill_next_if", state, 0);
        check("ill_cleared", illegal, 0);

        // sw with reset asserted in MW
        fetch(6'h2B, 6'h00);
        cyc();
        MIO_ready = 1'b0;
        cyc();
        check("mw_state", state, 5);
        check("mw_memwrite", MemWrite, 1);
        rst = 1'b1;
        #1;
        check("mw_rst_memwrite_now", MemWrite, 0);
        cyc();
        check("rst_after_mw_state", state, 0);
        check("rst_after_mw_memwrite", MemWrite, 0);
        rst = 1'b0;
        MIO_ready = 1'b1;
        #1;
        check("resume_memread", MemRead, 1);
        cyc();
        check("resume_id", state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
